// File: rtl/data_mem_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states and lane count.
package data_mem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_lane.sv
// Byte-lane helper: store lane mask and replication, load extract and extend.
// Alignment and illegal-size errors exist only with DATA_MEM_SIZED_ERR_CHECK_EN.
module data_mem_lane
  import data_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic        st_err,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_lanes = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_lanes = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef DATA_MEM_SIZED_ERR_CHECK_EN
  always_comb begin
    st_err = 1'b0;
    case (st_size)
      SZ_BYTE: st_err = 1'b0;
      SZ_HALF: st_err = st_addr_lo[0];
      SZ_WORD: st_err = (st_addr_lo != 2'b00);
      default: st_err = 1'b1;
    endcase
  end
`else
  assign st_err = 1'b0;
`endif

  always_comb begin
    ld_byte = 8'(ld_word >> {ld_addr_lo, 3'b000});
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Sized load/store data memory with a fixed wait-state pipeline (IDLE/WAIT/RESP).
// Define DATA_MEM_SIZED_ERR_CHECK_EN to reject misaligned and illegal-size requests.
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [1:0]                 req_size,
  input  logic                       req_signed,
  input  logic [$clog2(DEPTH)+1:0]   req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err
);

  localparam int AW = $clog2(DEPTH) + 2;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            enter_resp;

  logic            acc_write;
  logic [1:0]      acc_size;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      st_be;
  logic [31:0]     st_lanes;
  logic            acc_err;
  logic [31:0]     mem_rdata;
  logic [31:0]     ld_data;

  // With zero wait states the array is touched on the accept edge itself,
  // so the access path must see the live request rather than the registers.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = write_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP) && !reset;
    err_d      = enter_resp ? acc_err : err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  data_mem_lane u_lane (
    .st_size    (acc_size),
    .st_addr_lo (acc_addr[1:0]),
    .st_wdata   (acc_wdata),
    .st_be      (st_be),
    .st_lanes   (st_lanes),
    .st_err     (acc_err),
    .ld_size    (size_q),
    .ld_addr_lo (addr_q[1:0]),
    .ld_signed  (signed_q),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data)
  );

  // One byte-wide array per lane; no reset so contents survive it.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clock) begin
      if (enter_resp) begin
        if (acc_write && !acc_err && st_be[gi])
          mem[acc_addr[AW-1:2]] <= st_lanes[8*gi +: 8];
        rd_q <= mem[acc_addr[AW-1:2]];
      end
    end

    assign mem_rdata[8*gi +: 8] = rd_q;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP) && !reset;
  assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? ld_data : 32'd0;

`ifdef DATA_MEM_SIZED_ERR_CHECK_EN
  assign rsp_err = rsp_valid && err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_sized.sv
// Randomized self-checking bench for data_mem_sized against a byte-array reference model.
module tb_data_mem_sized;
  localparam int DEPTH = 64;
  localparam int WS    = 3;
  localparam int AW    = $clog2(DEPTH) + 2;
  localparam int NB    = DEPTH * 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;
  logic [7:0] mdl [NB];

  always #5 clock = ~clock;

  data_mem_sized #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input int a);
`ifdef DATA_MEM_SIZED_ERR_CHECK_EN
    return (sz == 2'd3) || (a % nbytes(sz) != 0);
`else
    return (sz == 2'd3) && (a < 0);
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input int a);
    int n = nbytes(sz);
    int s = a - (a % n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[s + i]) << (8 * i));
    if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] sz, input int a, input logic [31:0] d);
    int n = nbytes(sz);
    int s = a - (a % n);
    for (int i = 0; i < n; i++) mdl[s + i] = 8'(d >> (8 * i));
  endfunction

  // One full request: drive, observe the response window, compare with the model.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input int a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int lat = 0;
    int np = 0;
    int busy_ready = 0;
    int noisy = 0;
    logic exp_err;
    logic [31:0] exp_rd;
    exp_err = model_err(sz, a);
    exp_rd  = (wr || exp_err) ? 32'd0 : model_load(sz, sg, a);
    if (wr && !exp_err) model_store(sz, a, wd);
    rd = 32'd0;
    er = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = AW'(a); req_wdata = wd;
    check("ready_idle", 32'(req_ready), 32'd1);
    for (int k = 1; k <= WS + 2; k++) begin
      @(negedge clock);
      if (k == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        np++; lat = k; rd = rsp_rdata; er = rsp_err;
      end else if (rsp_rdata != 32'd0 || rsp_err) noisy++;
      if (k <= WS + 1 && req_ready) busy_ready++;
    end
    check("latency", 32'(lat), 32'(WS + 1));
    check("pulses", 32'(np), 32'd1);
    check("ready_busy", 32'(busy_ready), 32'd0);
    check("quiet_outputs", 32'(noisy), 32'd0);
    check("rdata", rd, exp_rd);
    check("err", 32'(er), 32'(exp_err));
    $display("txn %0d wr=%0d size=%0d signed=%0d addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0d",
             txn, wr, sz, sg, a, wd, rd, er);
    txn++;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int accepts;
    int pulses;
    logic [31:0] exp_w;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    check("post_reset_ready", 32'(req_ready), 32'd1);
    check("post_reset_err", 32'(rsp_err), 32'd0);

    // Give every word a known value so random loads are predictable.
    for (int w = 0; w < DEPTH; w++) do_req(1'b1, 2'd2, 1'b0, 4 * w, $urandom, rd, er);

    do_req(1'b1, 2'd2, 1'b0, 'h10, 32'hDEADBEEF, rd, er);
    do_req(1'b0, 2'd2, 1'b1, 'h10, 32'd0, rd, er);
    check("word_load", rd, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 'h11, 32'h0000007A, rd, er);
    do_req(1'b0, 2'd2, 1'b0, 'h10, 32'd0, rd, er);
    check("byte_merge", rd, 32'hDEAD7AEF);
    do_req(1'b0, 2'd0, 1'b1, 'h13, 32'd0, rd, er);
    check("byte_signed", rd, 32'hFFFFFFDE);
    do_req(1'b0, 2'd0, 1'b0, 'h13, 32'd0, rd, er);
    check("byte_unsigned", rd, 32'h000000DE);
    do_req(1'b0, 2'd1, 1'b1, 'h12, 32'd0, rd, er);
    check("half_signed", rd, 32'hFFFFDEAD);
    do_req(1'b0, 2'd1, 1'b0, 'h12, 32'd0, rd, er);
    check("half_unsigned", rd, 32'h0000DEAD);
    do_req(1'b1, 2'd1, 1'b0, 'h11, 32'h0000CAFE, rd, er);
`ifdef DATA_MEM_SIZED_ERR_CHECK_EN
    check("misaligned_err", 32'(er), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 'h10, 32'd0, rd, er);
    check("misaligned_nowrite", rd, 32'hDEAD7AEF);
`else
    check("misaligned_noerr", 32'(er), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 'h10, 32'd0, rd, er);
    check("misaligned_half", rd, 32'hDEADCAFE);
`endif

    // Reset two cycles after accepting a store: no response and no write.
    exp_w = model_load(2'd2, 1'b0, 'h20);
    pulses = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = AW'('h20); req_wdata = 32'h12345678;
    @(negedge clock);
    req_valid = 1'b0;
    if (rsp_valid) pulses++;
    @(negedge clock);
    if (rsp_valid) pulses++;
    reset = 1'b1;
    @(negedge clock);
    if (rsp_valid) pulses++;
    check("abort_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    check("abort_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < WS + 3; k++) begin
      @(negedge clock);
      if (rsp_valid) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 'h20, 32'd0, rd, er);
    check("abort_nowrite", rd, exp_w);

    // req_valid held high: one accept per WS+2 cycles, one response each.
    exp_w = model_load(2'd2, 1'b1, 'h10);
    accepts = 0;
    pulses = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b1;
    req_addr = AW'('h10); req_wdata = 32'd0;
    for (int k = 0; k < 3 * (WS + 2); k++) begin
      if (req_ready) accepts++;
      if (rsp_valid) begin
        pulses++;
        check("hold_rdata", rsp_rdata, exp_w);
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    for (int k = 0; k < WS + 3; k++) begin
      if (rsp_valid) pulses++;
      @(negedge clock);
    end
    check("hold_accepts", 32'(accepts), 32'd3);
    check("hold_pulses", 32'(pulses), 32'd3);

    for (int i = 0; i < 250; i++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, NB - 1)), $urandom, rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 SHALL provide parameter DEPTH, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL provide parameter WAIT_STATES, default 1, extra cycles between accept and array access (0..15).
REQ-003 SHALL provide port clock  input  1  single clock, all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port req_valid  input  1  request present.
REQ-006 SHALL provide port req_ready  output  1  block can accept a request.
REQ-007 SHALL provide port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL provide port req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 SHALL provide port req_signed  input  1  load sign-extend (1) or zero-extend (0).
REQ-010 SHALL provide port req_addr  input  log2(DEPTH)+2  byte address.
REQ-011 SHALL provide port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL provide port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL provide port rsp_rdata  output  32  load result, right-aligned and extended.
REQ-014 SHALL provide port rsp_err  output  1  request rejected, no array access.

Function
REQ-015 SHALL use an FSM with states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid & req_ready, registering all req_* fields.
REQ-017 SHALL go IDLE->WAIT on accept when WAIT_STATES>0, else IDLE->RESP.
REQ-018 SHALL remain in WAIT for exactly WAIT_STATES cycles using a down-counter, then enter RESP.
REQ-019 SHALL perform the array read or write on the edge entering RESP; rsp_valid is high for the single RESP cycle.
REQ-020 SHALL return RESP->IDLE unconditionally, with no response backpressure; accept-to-rsp_valid latency = WAIT_STATES+1 cycles; max one request per WAIT_STATES+2 cycles.
REQ-021 SHALL, on store, write only addressed lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0..1}; word -> all four lanes; other lanes unchanged.
REQ-022 SHALL, on load, extract the addressed byte/half/word and sign- or zero-extend it to 32 bits per the registered req_signed.
REQ-023 SHALL drive rsp_rdata = 0 on stores, on errors, and in every cycle rsp_valid is low.
REQ-024 SHALL ignore req_valid while req_ready is low; such requests are neither queued nor answered.

Reset
REQ-025 SHALL, while reset is high, force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready reads 1 after the reset edge.
REQ-026 SHALL abort a request in WAIT or RESP when reset asserts; a store still in WAIT is never written.
REQ-027 SHALL not clear array contents on reset.

Configuration
REQ-028 SHALL use macro DATA_MEM_SIZED_ERR_CHECK_EN for misalignment and illegal-size checking.
REQ-029 SHALL, with DATA_MEM_SIZED_ERR_CHECK_EN defined, treat half at odd address, word with addr[1:0]!=0, or size 11 as an error: no array access, rsp_err=1 during RESP, same latency.
REQ-030 SHALL, without DATA_MEM_SIZED_ERR_CHECK_EN, tie rsp_err to 0, ignore addr[0] for half and addr[1:0] for word, and treat size 11 as word.

Structure
REQ-031 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and the lane-count constant in package data_mem_pkg.
REQ-032 SHALL place store lane-mask generation and load extract/extend in the combinational sub-module data_mem_lane.
REQ-033 SHALL hold the array as DEPTH x 4 byte lanes, inferable as byte-enable block RAM.

Verification
REQ-034 Store word 0xDEADBEEF @0x10, then load word signed @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly WAIT_STATES+1 cycles after each accept.
REQ-035 After REQ-034, store byte 0x7A @0x11, then load word @0x10 -> 0xDEAD7AEF; load byte signed @0x13 -> 0xFFFFFFDE; load byte unsigned @0x13 -> 0x000000DE.
REQ-036 Load half signed @0x12 -> 0xFFFFDEAD; load half unsigned -> 0x0000DEAD.
REQ-037 With ERR_CHECK_EN: store half @0x11 -> rsp_err 1, rsp_rdata 0; then load word @0x10 -> unchanged 0xDEAD7AEF. Without: same store writes lanes 0..1 of word 0x10.
REQ-038 With WAIT_STATES=3, store word 0x12345678 @0x20, assert reset 2 cycles after accept -> no rsp_valid; then load @0x20 -> prior contents.
REQ-039 Hold req_valid high continuously -> req_ready low during WAIT/RESP, exactly one response per accept, and no extra array access.
